// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : EX-stage operand forwarding plus load-use, MUL/DIV and branch
//               stall/flush control for a 5-stage RISC-V pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MULDIV_CYCLES     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] readReg1_ID,
    input  logic [REG_ADDR_W-1:0] readReg2_ID,
    input  logic [REG_ADDR_W-1:0] readReg1_EX,
    input  logic [REG_ADDR_W-1:0] readReg2_EX,
    input  logic                  memRead_IDtoEX,
    input  logic [REG_ADDR_W-1:0] writeReg_IDtoEX,
    input  logic                  regWrite_EXtoMEM,
    input  logic [REG_ADDR_W-1:0] writeReg_EXtoMEM,
    input  logic                  regWrite_MEMtoWB,
    input  logic [REG_ADDR_W-1:0] writeReg_MEMtoWB,
    input  logic                  mulDivStart,
    input  logic                  branchTaken_EX,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  flushM,
    output logic                  mdBusy
);

    localparam int MAX_CYCLES = (LOAD_STALL_CYCLES > MULDIV_CYCLES) ? LOAD_STALL_CYCLES : MULDIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] C_LOAD_INIT = CNT_W'(LOAD_STALL_CYCLES - 2);
    localparam logic [CNT_W-1:0] C_MD_INIT   = CNT_W'(MULDIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] C_ST_IDLE       = 2'd0;
    localparam logic [1:0] C_ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] C_ST_MD_BUSY    = 2'd2;

    localparam logic [1:0] C_FWD_RF  = 2'b00;
    localparam logic [1:0] C_FWD_WB  = 2'b01;
    localparam logic [1:0] C_FWD_MEM = 2'b10;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             w_load_use;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = C_FWD_RF;
        if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
            sel = C_FWD_MEM;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
            sel = C_FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        w_fwd_a = fwd_sel(readReg1_EX, regWrite_EXtoMEM, writeReg_EXtoMEM,
                          regWrite_MEMtoWB, writeReg_MEMtoWB);
        w_fwd_b = fwd_sel(readReg2_EX, regWrite_EXtoMEM, writeReg_EXtoMEM,
                          regWrite_MEMtoWB, writeReg_MEMtoWB);
        w_load_use = memRead_IDtoEX && (writeReg_IDtoEX != '0) &&
                     ((writeReg_IDtoEX == readReg1_ID) || (writeReg_IDtoEX == readReg2_ID));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= C_ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. In MD_BUSY the counter holds the MD_BUSY cycles still
    // to run including the current one; the IDLE start cycle supplies the
    // first stall cycle, so total occupancy is MULDIV_CYCLES-1 stalled cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            C_ST_IDLE: begin
                if (branchTaken_EX) begin
                    state_d = C_ST_IDLE;
                end else if (mulDivStart) begin
                    if (MULDIV_CYCLES > 2) begin
                        state_d = C_ST_MD_BUSY;
                        cnt_d   = C_MD_INIT;
                    end
                end else if (w_load_use) begin
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = C_ST_LOAD_STALL;
                        cnt_d   = C_LOAD_INIT;
                    end
                end
            end
            C_ST_LOAD_STALL: begin
                if (cnt_q == '0) begin
                    state_d = C_ST_IDLE;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            C_ST_MD_BUSY: begin
                if (cnt_q <= C_CNT_ONE) begin
                    state_d = C_ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic; everything is forced low while reset is held
    always_comb begin
        forwardA = C_FWD_RF;
        forwardB = C_FWD_RF;
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        flushM   = 1'b0;
        mdBusy   = 1'b0;
        if (!reset) begin
            forwardA = w_fwd_a;
            forwardB = w_fwd_b;
            case (state_q)
                C_ST_IDLE: begin
                    if (branchTaken_EX) begin
                        flushD = 1'b1;
                        flushE = 1'b1;
                    end else if (mulDivStart) begin
                        mdBusy = 1'b1;
                        stallF = 1'b1;
                        stallD = 1'b1;
                        stallE = 1'b1;
                        flushM = 1'b1;
                    end else if (w_load_use) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end
                end
                C_ST_LOAD_STALL: begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
                C_ST_MD_BUSY: begin
                    mdBusy = 1'b1;
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    flushM = 1'b1;
                end
                default: begin
                    stallF = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Directed self-checking bench for hazard_control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_idex, rd_mem, rd_wb;
    logic       mem_read, we_mem, we_wb, md_start, br_taken;

    int n_tests;
    int n_fail;

    // Packed as {forwardA, forwardB, stallF, stallD, stallE, flushD, flushE, flushM, mdBusy}
    logic [10:0] out_a, out_b, out_c;

    localparam logic [10:0] C_IDLE_OUT = 11'b00_00_0000000;
    localparam logic [10:0] C_LOAD_OUT = 11'b00_00_1100100;
    localparam logic [10:0] C_MD_OUT   = 11'b00_00_1110011;
    localparam logic [10:0] C_BR_OUT   = 11'b00_00_0001100;

    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .MULDIV_CYCLES(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .readReg1_ID(rs1_id[4:0]), .readReg2_ID(rs2_id[4:0]),
        .readReg1_EX(rs1_ex[4:0]), .readReg2_EX(rs2_ex[4:0]),
        .memRead_IDtoEX(mem_read), .writeReg_IDtoEX(rd_idex[4:0]),
        .regWrite_EXtoMEM(we_mem), .writeReg_EXtoMEM(rd_mem[4:0]),
        .regWrite_MEMtoWB(we_wb), .writeReg_MEMtoWB(rd_wb[4:0]),
        .mulDivStart(md_start), .branchTaken_EX(br_taken),
        .forwardA(out_a[10:9]), .forwardB(out_a[8:7]),
        .stallF(out_a[6]), .stallD(out_a[5]), .stallE(out_a[4]),
        .flushD(out_a[3]), .flushE(out_a[2]), .flushM(out_a[1]), .mdBusy(out_a[0])
    );

    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .MULDIV_CYCLES(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .readReg1_ID(rs1_id[4:0]), .readReg2_ID(rs2_id[4:0]),
        .readReg1_EX(rs1_ex[4:0]), .readReg2_EX(rs2_ex[4:0]),
        .memRead_IDtoEX(mem_read), .writeReg_IDtoEX(rd_idex[4:0]),
        .regWrite_EXtoMEM(we_mem), .writeReg_EXtoMEM(rd_mem[4:0]),
        .regWrite_MEMtoWB(we_wb), .writeReg_MEMtoWB(rd_wb[4:0]),
        .mulDivStart(md_start), .branchTaken_EX(br_taken),
        .forwardA(out_b[10:9]), .forwardB(out_b[8:7]),
        .stallF(out_b[6]), .stallD(out_b[5]), .stallE(out_b[4]),
        .flushD(out_b[3]), .flushE(out_b[2]), .flushM(out_b[1]), .mdBusy(out_b[0])
    );

    hazard_control_unit #(.REG_ADDR_W(6), .LOAD_STALL_CYCLES(1), .MULDIV_CYCLES(4)) u_dut_c (
        .clk(clk), .reset(reset),
        .readReg1_ID(rs1_id), .readReg2_ID(rs2_id),
        .readReg1_EX(rs1_ex), .readReg2_EX(rs2_ex),
        .memRead_IDtoEX(mem_read), .writeReg_IDtoEX(rd_idex),
        .regWrite_EXtoMEM(we_mem), .writeReg_EXtoMEM(rd_mem),
        .regWrite_MEMtoWB(we_wb), .writeReg_MEMtoWB(rd_wb),
        .mulDivStart(md_start), .branchTaken_EX(br_taken),
        .forwardA(out_c[10:9]), .forwardB(out_c[8:7]),
        .stallF(out_c[6]), .stallD(out_c[5]), .stallE(out_c[4]),
        .flushD(out_c[3]), .flushE(out_c[2]), .flushM(out_c[1]), .mdBusy(out_c[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0;
        rd_idex = '0; rd_mem = '0; rd_wb = '0;
        mem_read = 1'b0; we_mem = 1'b0; we_wb = 1'b0;
        md_start = 1'b0; br_taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();
        reset = 1'b1;

        // Reset forces all outputs low even with a forwarding match present
        we_mem = 1'b1; rd_mem = 6'd5; rs1_ex = 6'd5; rs2_ex = 6'd5;
        next_cycle(); settle();
        check("reset_a", 32'(out_a), 32'(C_IDLE_OUT));
        check("reset_c", 32'(out_c), 32'(C_IDLE_OUT));

        // Forwarding priority and x0 suppression
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        we_mem = 1'b1; rd_mem = 6'd5; we_wb = 1'b1; rd_wb = 6'd5;
        rs1_ex = 6'd5; rs2_ex = 6'd5;
        settle();
        check("fwd_mem", 32'(out_a), 32'({2'b10, 2'b10, 7'b0}));
        we_mem = 1'b0;
        settle();
        check("fwd_wb", 32'(out_a), 32'({2'b01, 2'b01, 7'b0}));
        we_mem = 1'b1; rd_mem = 6'd0; rd_wb = 6'd0; rs1_ex = 6'd0; rs2_ex = 6'd0;
        settle();
        check("fwd_x0", 32'(out_a), 32'(C_IDLE_OUT));

        // Wide address: WB writes x40, EX reads x40 on operand B only
        clear_inputs();
        we_wb = 1'b1; rd_wb = 6'd40; rs2_ex = 6'd40; rs1_ex = 6'd8;
        we_mem = 1'b1; rd_mem = 6'd9;
        settle();
        check("fwd_wide_c", 32'(out_c), 32'({2'b00, 2'b01, 7'b0}));

        // Load to x0 never stalls
        clear_inputs();
        mem_read = 1'b1; rd_idex = 6'd0; rs1_id = 6'd0; rs2_id = 6'd0;
        settle();
        check("load_x0_c", 32'(out_c), 32'(C_IDLE_OUT));
        check("load_x0_a", 32'(out_a), 32'(C_IDLE_OUT));

        // Load-use on x7: one-cycle stall on A, three-cycle stall on B
        next_cycle();
        clear_inputs();
        mem_read = 1'b1; rd_idex = 6'd7; rs1_id = 6'd7;
        settle();
        check("lu_c0_a", 32'(out_a), 32'(C_LOAD_OUT));
        check("lu_c0_b", 32'(out_b), 32'(C_LOAD_OUT));
        next_cycle();
        clear_inputs();
        settle();
        check("lu_c1_a", 32'(out_a), 32'(C_IDLE_OUT));
        check("lu_c1_b", 32'(out_b), 32'(C_LOAD_OUT));
        next_cycle(); settle();
        check("lu_c2_b", 32'(out_b), 32'(C_LOAD_OUT));
        next_cycle(); settle();
        check("lu_c3_b", 32'(out_b), 32'(C_IDLE_OUT));

        // Load-use through the second ID source
        next_cycle();
        mem_read = 1'b1; rd_idex = 6'd12; rs2_id = 6'd12; rs1_id = 6'd3;
        settle();
        check("lu_rs2_a", 32'(out_a), 32'(C_LOAD_OUT));
        clear_inputs();
        next_cycle(); next_cycle(); next_cycle();

        // MUL/DIV: three stalled cycles, branch ignored, forwarding still live
        next_cycle();
        md_start = 1'b1;
        settle();
        check("md_c0", 32'(out_a), 32'(C_MD_OUT));
        next_cycle();
        md_start = 1'b0; br_taken = 1'b1;
        we_mem = 1'b1; rd_mem = 6'd3; rs1_ex = 6'd3;
        settle();
        check("md_c1_fwd", 32'(out_a), 32'({2'b10, 2'b00, 7'b1110011}));
        next_cycle();
        clear_inputs();
        settle();
        check("md_c2", 32'(out_a), 32'(C_MD_OUT));
        next_cycle(); settle();
        check("md_done", 32'(out_a), 32'(C_IDLE_OUT));

        // Branch wins over a simultaneous load-use
        next_cycle();
        br_taken = 1'b1; mem_read = 1'b1; rd_idex = 6'd7; rs1_id = 6'd7;
        settle();
        check("br_lu_a", 32'(out_a), 32'(C_BR_OUT));
        check("br_lu_b", 32'(out_b), 32'(C_BR_OUT));
        next_cycle();
        clear_inputs();
        settle();
        check("br_after_b", 32'(out_b), 32'(C_IDLE_OUT));

        // Reset during MD_BUSY aborts the stall
        next_cycle();
        md_start = 1'b1;
        settle();
        next_cycle();
        md_start = 1'b0; reset = 1'b1;
        we_mem = 1'b1; rd_mem = 6'd4; rs1_ex = 6'd4;
        settle();
        check("rst_mid_md", 32'(out_a), 32'(C_IDLE_OUT));
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        settle();
        check("rst_after0", 32'(out_a), 32'(C_IDLE_OUT));
        next_cycle(); settle();
        check("rst_after1", 32'(out_a), 32'(C_IDLE_OUT));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
